// File: rtl/ifetch.sv
// Instruction fetch sequencer: latches the PC on request, runs a read handshake
// with instruction memory, loads IR and signals the control unit to advance PC.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | read strobe asserted, waiting for mem_ready
// DONE  | IR loaded, done/inc_pc pulse for one cycle
// FAULT | timeout or misaligned PC, held until flush
module ifetch #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] IR_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [15:0] pc,
    input  logic        ir_en,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic [15:0] ir_out,
    output logic [15:0] ir_ungated,
    output logic        inc_pc,
    output logic        done,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [15:0] ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ir       <= IR_RESET;
            mem_addr <= '0;
            wait_cnt <= '0;
        end else if (flush) begin
            // flush outranks a same-cycle mem_ready: no IR load, no pulse
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (pc[0]) begin
                            state <= FAULT;
                        end else begin
                            mem_addr <= pc;
                            wait_cnt <= '0;
                            state    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= DONE;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state <= FAULT;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_rd     = (state == REQ);
    assign done       = (state == DONE);
    assign inc_pc     = (state == DONE);
    assign busy       = (state != IDLE);
    assign fault      = (state == FAULT);
    assign ir_ungated = ir;
    assign ir_out     = ir_en ? ir : 16'hzzzz;

endmodule

// File: tb/tb_ifetch.sv
// Directed plus randomized bench for ifetch; expectations come from a
// transaction-level model of the fetch rules (latency, timeout, alignment).
module tb_ifetch;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic        ir_en = 1'b0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    wire  [15:0] mem_addr;
    wire         mem_rd;
    wire  [15:0] ir_out;
    wire  [15:0] ir_ungated;
    wire         inc_pc;
    wire         done;
    wire         busy;
    wire         fault;

    int vectors = 0;
    int errors  = 0;
    logic [15:0] ir_model = 16'h0000;

    ifetch #(.TIMEOUT(TO), .IR_RESET(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .flush      (flush),
        .pc         (pc),
        .ir_en      (ir_en),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .ir_out     (ir_out),
        .ir_ungated (ir_ungated),
        .inc_pc     (inc_pc),
        .done       (done),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // flags packed as {mem_rd, done, inc_pc, busy, fault}
    task automatic expect_out(input string tag, input logic rd, input logic dn,
                              input logic bz, input logic flt);
        chk(tag, {11'b0, mem_rd, done, inc_pc, busy, fault},
                 {11'b0, rd, dn, dn, bz, flt});
    endtask

    // One fetch from IDLE: ready arrives on REQ cycle index dly (never if dly > TO).
    task automatic fetch(input string tag, input logic [15:0] a, input int dly,
                         input logic [15:0] data, input logic start_in_done);
        int n_rd;
        pc = a;
        start = 1'b1;
        mem_ready = 1'b0;
        tick();
        start = 1'b0;
        if (a[0]) begin
            expect_out({tag, "_misalign"}, 1'b0, 1'b0, 1'b1, 1'b1);
            chk({tag, "_ir_kept"}, ir_ungated, ir_model);
            return;
        end
        pc = 16'($urandom);
        n_rd = (dly > TO) ? TO + 1 : dly + 1;
        for (int c = 0; c < n_rd; c++) begin
            expect_out({tag, "_req"}, 1'b1, 1'b0, 1'b1, 1'b0);
            chk({tag, "_addr"}, mem_addr, a);
            chk({tag, "_ir_wait"}, ir_ungated, ir_model);
            mem_ready = (c == dly);
            mem_rdata = (c == dly) ? data : 16'($urandom);
            tick();
        end
        mem_ready = 1'b0;
        if (dly <= TO) begin
            ir_model = data;
            expect_out({tag, "_done"}, 1'b0, 1'b1, 1'b1, 1'b0);
            chk({tag, "_ir"}, ir_ungated, ir_model);
            start = start_in_done;
            tick();
            start = 1'b0;
            expect_out({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            expect_out({tag, "_timeout"}, 1'b0, 1'b0, 1'b1, 1'b1);
            chk({tag, "_ir_kept"}, ir_ungated, ir_model);
        end
    endtask

    task automatic clear_fault(input string tag);
        start = 1'b1;
        pc = 16'h0400;
        tick();
        start = 1'b0;
        expect_out({tag, "_start_ignored"}, 1'b0, 1'b0, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out({tag, "_flushed"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_ir_gate(input string tag);
        ir_en = 1'b1;
        #1;
        chk({tag, "_ir_on"}, ir_out, ir_model);
        ir_en = 1'b0;
        #1;
        chk({tag, "_ir_off"}, ir_out, 16'hzzzz);
        chk({tag, "_ungated"}, ir_ungated, ir_model);
    endtask

    initial begin
        int dly;
        logic [15:0] a;

        tick();
        tick();
        reset = 1'b0;
        expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_addr", mem_addr, 16'h0000);
        chk("reset_ir", ir_ungated, 16'h0000);

        // zero-wait fetch
        fetch("t1", 16'h0200, 0, 16'h1234, 1'b0);
        chk("t1_addr_hold", mem_addr, 16'h0200);

        // ready delayed 3 cycles, PC moved mid-fetch, start during DONE ignored
        fetch("t2", 16'h0200, 3, 16'hBEEF, 1'b1);

        // timeout then recovery
        fetch("t3", 16'h0210, TO + 1, 16'h5555, 1'b0);
        clear_fault("t3");

        // misaligned PC
        fetch("t4", 16'h0201, 0, 16'h0000, 1'b0);
        clear_fault("t4");

        // flush and mem_ready together in REQ
        pc = 16'h0220;
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hDEAD;
        flush = 1'b1;
        tick();
        mem_ready = 1'b0;
        flush = 1'b0;
        expect_out("t5_flush", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_ir_kept", ir_ungated, ir_model);

        // flush during DONE: pulse already visible, then IDLE
        pc = 16'h0230;
        start = 1'b1;
        tick();
        start = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 16'hC0DE;
        tick();
        mem_ready = 1'b0;
        ir_model = 16'hC0DE;
        expect_out("t5_done_pulse", 1'b0, 1'b1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expect_out("t5_done_flush", 1'b0, 1'b0, 1'b0, 1'b0);

        check_ir_gate("t6");

        // reset mid-REQ
        pc = 16'h0240;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        mem_ready = 1'b1;
        tick();
        reset = 1'b0;
        mem_ready = 1'b0;
        ir_model = 16'h0000;
        expect_out("t5_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_reset_addr", mem_addr, 16'h0000);
        chk("t5_reset_ir", ir_ungated, ir_model);

        // randomized fetches
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            if ($urandom_range(0, 9) < 7) dly = $urandom_range(0, 5);
            else dly = $urandom_range(TO - 1, TO + 3);
            fetch("rnd", a, dly, 16'($urandom), 1'($urandom));
            if (fault) clear_fault("rnd");
            else check_ir_gate("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
